// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: command op codes, major opcodes, fixed words and
// field-packing helpers used by the encoder and the decoder.
package riscv_pkg;

    typedef enum logic [3:0] {
        OP_ADD    = 4'd0,
        OP_SUB    = 4'd1,
        OP_ADDI   = 4'd2,
        OP_LUI    = 4'd3,
        OP_AUIPC  = 4'd4,
        OP_JAL    = 4'd5,
        OP_JALR   = 4'd6,
        OP_BEQ    = 4'd7,
        OP_BNE    = 4'd8,
        OP_LW     = 4'd9,
        OP_SW     = 4'd10,
        OP_CSRRW  = 4'd11,
        OP_ECALL  = 4'd12,
        OP_EBREAK = 4'd13,
        OP_MRET   = 4'd14,
        OP_LI     = 4'd15
    } op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_LI_LO = 1'b1
    } enc_state_e;

    localparam logic [6:0] OPC_R      = 7'h33;
    localparam logic [6:0] OPC_IALU   = 7'h13;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_SYSTEM = 7'h73;

    localparam logic [31:0] NOP_WORD    = 32'h0000_0013;
    localparam logic [31:0] ECALL_WORD  = 32'h0000_0073;
    localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;
    localparam logic [31:0] MRET_WORD   = 32'h3020_0073;

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] opc);
        return {f7, rs2, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:1] off, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], OPC_BRANCH};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] hi, input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {hi, rd, opc};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:1] off, input logic [4:0] rd);
        return {off[20], off[10:1], off[11], off[19:12], rd, OPC_JAL};
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Command-in / instruction-out bundle of the encoder; master is the command
// source and instruction sink, slave is the encoder side.
interface instr_encoder_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [4:0]  cmd_rd;
    logic [4:0]  cmd_rs1;
    logic [4:0]  cmd_rs2;
    logic [31:0] cmd_imm;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        err;

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, instr_ready,
        input  cmd_ready, instr, instr_valid, err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, instr_ready,
        output cmd_ready, instr, instr_valid, err
    );
endinterface

// File: rtl/imm_range_check.sv
// Combinational legality check of a command's immediate against the field
// width of the instruction format it will be packed into.
module imm_range_check
    import riscv_pkg::*;
#(
    parameter bit LI_EXPAND = 1'b1
) (
    input  op_e         op_i,
    input  logic [31:0] imm_i,
    output logic        ok_o
);

    logic fits12_s;
    logic fits13_s;
    logic fits21_s;
    logic even_s;

    // Sign-extension checks: all bits above the field's sign bit must match it.
    assign fits12_s = (&imm_i[31:11]) | ~(|imm_i[31:11]);
    assign fits13_s = (&imm_i[31:12]) | ~(|imm_i[31:12]);
    assign fits21_s = (&imm_i[31:20]) | ~(|imm_i[31:20]);
    assign even_s   = ~imm_i[0];

    // Per-op acceptance.
    always_comb begin
        ok_o = 1'b1;
        case (op_i)
            OP_ADDI, OP_JALR, OP_LW, OP_SW: ok_o = fits12_s;
            OP_BEQ, OP_BNE:                 ok_o = fits13_s & even_s;
            OP_JAL:                         ok_o = fits21_s & even_s;
            OP_LUI, OP_AUIPC:               ok_o = ~(|imm_i[11:0]);
            OP_CSRRW:                       ok_o = ~(|imm_i[31:12]);
            OP_LI:                          ok_o = LI_EXPAND;
            default:                        ok_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Turns symbolic commands into RV32I words with one-cycle latency; LI may
// expand into a LUI/ADDI pair, held through the LI_LO state.
module instr_encoder
    import riscv_pkg::*;
#(
    parameter bit LI_EXPAND = 1'b1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [3:0]  cmd_op_i,
    input  logic [4:0]  cmd_rd_i,
    input  logic [4:0]  cmd_rs1_i,
    input  logic [4:0]  cmd_rs2_i,
    input  logic [31:0] cmd_imm_i,
    output logic [31:0] instr_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic        err_o
);

    enc_state_e  state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic [31:0] pend_q, pend_d;

    op_e         op_s;
    logic        ok_s;
    logic        accept_s;
    logic        fits12_s;
    logic [19:0] li_hi_s;
    logic [31:0] enc_word_s;
    logic [31:0] lo_word_s;
    logic        need_lo_s;

    assign op_s     = op_e'(cmd_op_i);
    assign fits12_s = (&cmd_imm_i[31:11]) | ~(|cmd_imm_i[31:11]);
    // Rounds the upper part so that the sign-extended low 12 bits restore imm.
    assign li_hi_s  = cmd_imm_i[31:12] + {19'd0, cmd_imm_i[11]};

    imm_range_check #(.LI_EXPAND(LI_EXPAND)) u_range (
        .op_i  (op_s),
        .imm_i (cmd_imm_i),
        .ok_o  (ok_s)
    );

    assign cmd_ready_o   = ~reset_i & (state_q == ST_IDLE) & (~valid_q | instr_ready_i);
    assign accept_s      = cmd_valid_i & cmd_ready_o;
    assign instr_o       = instr_q;
    assign instr_valid_o = valid_q;
    assign err_o         = err_q;

    // Field packing of the incoming command.
    always_comb begin
        enc_word_s = NOP_WORD;
        lo_word_s  = NOP_WORD;
        need_lo_s  = 1'b0;
        case (op_s)
            OP_ADD:    enc_word_s = enc_r(7'h00, cmd_rs2_i, cmd_rs1_i, 3'd0, cmd_rd_i, OPC_R);
            OP_SUB:    enc_word_s = enc_r(7'h20, cmd_rs2_i, cmd_rs1_i, 3'd0, cmd_rd_i, OPC_R);
            OP_ADDI:   enc_word_s = enc_i(cmd_imm_i[11:0], cmd_rs1_i, 3'd0, cmd_rd_i, OPC_IALU);
            OP_LUI:    enc_word_s = enc_u(cmd_imm_i[31:12], cmd_rd_i, OPC_LUI);
            OP_AUIPC:  enc_word_s = enc_u(cmd_imm_i[31:12], cmd_rd_i, OPC_AUIPC);
            OP_JAL:    enc_word_s = enc_j(cmd_imm_i[20:1], cmd_rd_i);
            OP_JALR:   enc_word_s = enc_i(cmd_imm_i[11:0], cmd_rs1_i, 3'd0, cmd_rd_i, OPC_JALR);
            OP_BEQ:    enc_word_s = enc_b(cmd_imm_i[12:1], cmd_rs2_i, cmd_rs1_i, 3'd0);
            OP_BNE:    enc_word_s = enc_b(cmd_imm_i[12:1], cmd_rs2_i, cmd_rs1_i, 3'd1);
            OP_LW:     enc_word_s = enc_i(cmd_imm_i[11:0], cmd_rs1_i, 3'd2, cmd_rd_i, OPC_LOAD);
            OP_SW:     enc_word_s = enc_s(cmd_imm_i[11:0], cmd_rs2_i, cmd_rs1_i, 3'd2);
            OP_CSRRW:  enc_word_s = enc_i(cmd_imm_i[11:0], cmd_rs1_i, 3'd1, cmd_rd_i, OPC_SYSTEM);
            OP_ECALL:  enc_word_s = ECALL_WORD;
            OP_EBREAK: enc_word_s = EBREAK_WORD;
            OP_MRET:   enc_word_s = MRET_WORD;
            OP_LI: begin
                if (fits12_s) begin
                    enc_word_s = enc_i(cmd_imm_i[11:0], 5'd0, 3'd0, cmd_rd_i, OPC_IALU);
                end else begin
                    enc_word_s = enc_u(li_hi_s, cmd_rd_i, OPC_LUI);
                    lo_word_s  = enc_i(cmd_imm_i[11:0], cmd_rd_i, 3'd0, cmd_rd_i, OPC_IALU);
                    need_lo_s  = |cmd_imm_i[11:0];
                end
            end
            default:   enc_word_s = NOP_WORD;
        endcase
    end

    // Next-state and output-register update.
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        pend_d  = pend_q;
        err_d   = 1'b0;
        if (valid_q && instr_ready_i) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
        case (state_q)
            ST_IDLE: begin
                if (accept_s && ok_s) begin
                    instr_d = enc_word_s;
                    valid_d = 1'b1;
                    if (need_lo_s) begin
                        pend_d  = lo_word_s;
                        state_d = ST_LI_LO;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (accept_s) begin
                    err_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LI_LO: begin
                // LUI leaves the register this cycle; the ADDI replaces it with no bubble.
                if (instr_ready_i) begin
                    instr_d = pend_q;
                    valid_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_LI_LO;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            instr_q <= NOP_WORD;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            pend_q  <= NOP_WORD;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            pend_q  <= pend_d;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: expected words are queued as commands
// are driven and popped as the sink consumes instructions or sees err_o.
module tb_instr_encoder;
    import riscv_pkg::*;

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        err;
        logic [31:0] w0;
        logic        two;
        logic [31:0] w1;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    bit   rand_bp = 1'b0;
    logic [32:0] exp_q[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    instr_encoder_if bus();

    instr_encoder #(.LI_EXPAND(1'b1)) dut (
        .clk_i         (clk),
        .reset_i       (rst),
        .cmd_valid_i   (bus.cmd_valid),
        .cmd_ready_o   (bus.cmd_ready),
        .cmd_op_i      (bus.cmd_op),
        .cmd_rd_i      (bus.cmd_rd),
        .cmd_rs1_i     (bus.cmd_rs1),
        .cmd_rs2_i     (bus.cmd_rs2),
        .cmd_imm_i     (bus.cmd_imm),
        .instr_o       (bus.instr),
        .instr_valid_o (bus.instr_valid),
        .instr_ready_i (bus.instr_ready),
        .err_o         (bus.err)
    );

    // Independent RV32I legality check standing in for the decoder.
    function automatic bit legal(input logic [31:0] w);
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = w[14:12];
        f7 = w[31:25];
        case (w[6:0])
            7'h33:   return (f3 == 3'd0) && (f7 == 7'h00 || f7 == 7'h20);
            7'h13:   return f3 == 3'd0;
            7'h03:   return f3 == 3'd2;
            7'h23:   return f3 == 3'd2;
            7'h63:   return f3 == 3'd0 || f3 == 3'd1;
            7'h37, 7'h17, 7'h6F: return 1'b1;
            7'h67:   return f3 == 3'd0;
            7'h73:   return w == 32'h0000_0073 || w == 32'h0010_0073 ||
                            w == 32'h3020_0073 || f3 == 3'd1;
            default: return 1'b0;
        endcase
    endfunction

    // Scoreboard: every consumed instruction or error pulse pops one entry.
    always @(negedge clk) begin
        logic [32:0] e;
        logic [32:0] act;
        if (!rst && (bus.err || (bus.instr_valid && bus.instr_ready))) begin
            act = bus.err ? {1'b1, 31'd0, bus.instr_valid} : {1'b0, bus.instr};
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_output: got err=%0b word=%08h, none expected",
                         act[32], act[31:0]);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    fails++;
                    $display("FAIL scoreboard: got err=%0b word=%08h, expected err=%0b word=%08h",
                             act[32], act[31:0], e[32], e[31:0]);
                end
            end
            if (!bus.err) begin
                tests++;
                if (!legal(bus.instr)) begin
                    fails++;
                    $display("FAIL decode_legal: word %08h illegal, expected legal", bus.instr);
                end
            end
        end
    end

    task automatic drive_cmd(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [31:0] imm);
        int n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_rd    = rd;
        bus.cmd_rs1   = rs1;
        bus.cmd_rs2   = rs2;
        bus.cmd_imm   = imm;
        forever begin
            if (rand_bp) bus.instr_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (bus.cmd_ready) break;
            n++;
            if (n > 50) begin
                tests++;
                fails++;
                $display("FAIL accept_timeout: op %0d not accepted in 50 cycles, expected accept", op);
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        rand_bp = 1'b0;
        bus.instr_ready = 1'b1;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d outputs still pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if (bus.instr !== 32'h0000_0013 || bus.instr_valid !== 1'b0 ||
            bus.err !== 1'b0 || bus.cmd_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: word=%08h v=%0b err=%0b rdy=%0b, expected 00000013 0 0 0",
                     bus.instr, bus.instr_valid, bus.err, bus.cmd_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (bus.cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_ready: got %0b, expected 1", bus.cmd_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_table();
        foreach (tbl[i]) begin
            if (tbl[i].err) exp_q.push_back({1'b1, 32'h0});
            else            exp_q.push_back({1'b0, tbl[i].w0});
            if (tbl[i].two) exp_q.push_back({1'b0, tbl[i].w1});
            drive_cmd(tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm);
        end
        drain();
    endtask

    task automatic test_errors();
        logic [3:0]  ops[2]  = '{4'd2, 4'd7};
        logic [31:0] imms[2] = '{32'd2048, 32'd3};
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back({1'b1, 32'h0});
            drive_cmd(ops[i], 5'd1, 5'd2, 5'd3, imms[i]);
            @(negedge clk);
            tests++;
            if (bus.err !== 1'b1 || bus.instr_valid !== 1'b0) begin
                fails++;
                $display("FAIL err_pulse: err=%0b v=%0b, expected err=1 v=0", bus.err, bus.instr_valid);
            end
            @(negedge clk);
            tests++;
            if (bus.err !== 1'b0 || bus.instr_valid !== 1'b0) begin
                fails++;
                $display("FAIL err_one_cycle: err=%0b v=%0b, expected 0 0", bus.err, bus.instr_valid);
            end
            @(posedge clk);
            #1;
        end
        drain();
    endtask

    task automatic test_li();
        exp_q.push_back({1'b0, 32'h1234_62B7});
        exp_q.push_back({1'b0, 32'hFFF2_8293});
        drive_cmd(4'd15, 5'd5, 5'd0, 5'd0, 32'h1234_5FFF);
        @(negedge clk);
        tests++;
        if (bus.instr !== 32'h1234_62B7 || bus.instr_valid !== 1'b1 || bus.cmd_ready !== 1'b0) begin
            fails++;
            $display("FAIL li_lui: word=%08h v=%0b rdy=%0b, expected 123462B7 1 0",
                     bus.instr, bus.instr_valid, bus.cmd_ready);
        end
        @(negedge clk);
        tests++;
        if (bus.instr !== 32'hFFF2_8293 || bus.instr_valid !== 1'b1 || bus.cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL li_addi: word=%08h v=%0b rdy=%0b, expected FFF28293 1 1",
                     bus.instr, bus.instr_valid, bus.cmd_ready);
        end
        drain();
    endtask

    task automatic test_stall();
        bus.instr_ready = 1'b0;
        exp_q.push_back({1'b0, 32'h0000_0073});
        exp_q.push_back({1'b0, 32'h3020_0073});
        drive_cmd(4'd12, 5'd0, 5'd0, 5'd0, 32'h0);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 4'd14;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if (bus.instr !== 32'h0000_0073 || bus.instr_valid !== 1'b1 || bus.cmd_ready !== 1'b0) begin
                fails++;
                $display("FAIL stall_hold: word=%08h v=%0b rdy=%0b, expected 00000073 1 0",
                         bus.instr, bus.instr_valid, bus.cmd_ready);
            end
            @(posedge clk);
            #1;
        end
        bus.instr_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (bus.cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL stall_release_ready: got %0b, expected 1", bus.cmd_ready);
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (bus.instr !== 32'h3020_0073 || bus.instr_valid !== 1'b1) begin
            fails++;
            $display("FAIL stall_next: word=%08h v=%0b, expected 30200073 1", bus.instr, bus.instr_valid);
        end
        drain();
    endtask

    task automatic test_reset_mid_li();
        bus.instr_ready = 1'b0;
        drive_cmd(4'd15, 5'd5, 5'd0, 5'd0, 32'h1234_5FFF);
        @(negedge clk);
        tests++;
        if (bus.instr !== 32'h1234_62B7 || bus.instr_valid !== 1'b1 || bus.cmd_ready !== 1'b0) begin
            fails++;
            $display("FAIL midli_lui: word=%08h v=%0b rdy=%0b, expected 123462B7 1 0",
                     bus.instr, bus.instr_valid, bus.cmd_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.instr_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (bus.cmd_ready !== 1'b1 || bus.instr_valid !== 1'b0 || bus.instr !== 32'h0000_0013) begin
            fails++;
            $display("FAIL midli_after_reset: rdy=%0b v=%0b word=%08h, expected 1 0 00000013",
                     bus.cmd_ready, bus.instr_valid, bus.instr);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests++;
            if (bus.instr_valid !== 1'b0) begin
                fails++;
                $display("FAIL midli_no_addi: v=%0b word=%08h, expected v=0", bus.instr_valid, bus.instr);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [4:0] rd, rs1, rs2;
        logic       sub;
        rand_bp = 1'b1;
        for (int i = 0; i < 12; i++) begin
            rd  = 5'($urandom_range(0, 31));
            rs1 = 5'($urandom_range(0, 31));
            rs2 = 5'($urandom_range(0, 31));
            sub = 1'($urandom_range(0, 1));
            exp_q.push_back({1'b0, sub ? 7'h20 : 7'h00, rs2, rs1, 3'b000, rd, 7'h33});
            drive_cmd(sub ? 4'd1 : 4'd0, rd, rs1, rs2, 32'h0);
        end
        drain();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op = 4'd0;
        bus.cmd_rd = 5'd0;
        bus.cmd_rs1 = 5'd0;
        bus.cmd_rs2 = 5'd0;
        bus.cmd_imm = 32'h0;
        bus.instr_ready = 1'b1;
        // op rd rs1 rs2 imm err w0 two w1
        tbl.push_back('{4'd0,  5'd1,  5'd2, 5'd3, 32'h0000_0000, 1'b0, 32'h0031_00B3, 1'b0, 32'h0});
        tbl.push_back('{4'd1,  5'd1,  5'd2, 5'd3, 32'h0000_0000, 1'b0, 32'h4031_00B3, 1'b0, 32'h0});
        tbl.push_back('{4'd2,  5'd1,  5'd2, 5'd0, 32'hFFFF_FFFF, 1'b0, 32'hFFF1_0093, 1'b0, 32'h0});
        tbl.push_back('{4'd2,  5'd3,  5'd0, 5'd0, 32'h0000_07FF, 1'b0, 32'h7FF0_0193, 1'b0, 32'h0});
        tbl.push_back('{4'd3,  5'd10, 5'd0, 5'd0, 32'hDEAD_B000, 1'b0, 32'hDEAD_B537, 1'b0, 32'h0});
        tbl.push_back('{4'd4,  5'd2,  5'd0, 5'd0, 32'h0000_1000, 1'b0, 32'h0000_1117, 1'b0, 32'h0});
        tbl.push_back('{4'd5,  5'd1,  5'd0, 5'd0, 32'h0000_0800, 1'b0, 32'h0010_00EF, 1'b0, 32'h0});
        tbl.push_back('{4'd5,  5'd0,  5'd0, 5'd0, 32'hFFFF_FFFE, 1'b0, 32'hFFFF_F06F, 1'b0, 32'h0});
        tbl.push_back('{4'd5,  5'd0,  5'd0, 5'd0, 32'hFFF0_0000, 1'b0, 32'h8000_006F, 1'b0, 32'h0});
        tbl.push_back('{4'd5,  5'd0,  5'd0, 5'd0, 32'h000F_FFFE, 1'b0, 32'h7FFF_F06F, 1'b0, 32'h0});
        tbl.push_back('{4'd6,  5'd1,  5'd5, 5'd0, 32'h0000_0004, 1'b0, 32'h0042_80E7, 1'b0, 32'h0});
        tbl.push_back('{4'd7,  5'd0,  5'd1, 5'd2, 32'h0000_0008, 1'b0, 32'h0020_8463, 1'b0, 32'h0});
        tbl.push_back('{4'd8,  5'd0,  5'd1, 5'd2, 32'hFFFF_F000, 1'b0, 32'h8020_9063, 1'b0, 32'h0});
        tbl.push_back('{4'd8,  5'd0,  5'd1, 5'd2, 32'h0000_0FFE, 1'b0, 32'h7E20_9FE3, 1'b0, 32'h0});
        tbl.push_back('{4'd9,  5'd3,  5'd4, 5'd0, 32'hFFFF_F800, 1'b0, 32'h8002_2183, 1'b0, 32'h0});
        tbl.push_back('{4'd10, 5'd0,  5'd2, 5'd5, 32'h0000_000C, 1'b0, 32'h0051_2623, 1'b0, 32'h0});
        tbl.push_back('{4'd11, 5'd1,  5'd2, 5'd0, 32'h0000_0305, 1'b0, 32'h3051_10F3, 1'b0, 32'h0});
        tbl.push_back('{4'd12, 5'd7,  5'd7, 5'd7, 32'hFFFF_FFFF, 1'b0, 32'h0000_0073, 1'b0, 32'h0});
        tbl.push_back('{4'd13, 5'd7,  5'd7, 5'd7, 32'h0000_0000, 1'b0, 32'h0010_0073, 1'b0, 32'h0});
        tbl.push_back('{4'd15, 5'd6,  5'd0, 5'd0, 32'hFFFF_FFFB, 1'b0, 32'hFFB0_0313, 1'b0, 32'h0});
        tbl.push_back('{4'd15, 5'd7,  5'd0, 5'd0, 32'h0000_5000, 1'b0, 32'h0000_53B7, 1'b0, 32'h0});
        tbl.push_back('{4'd15, 5'd0,  5'd0, 5'd0, 32'h0000_0800, 1'b0, 32'h0000_1037, 1'b1, 32'h8000_0013});
        tbl.push_back('{4'd15, 5'd5,  5'd0, 5'd0, 32'h1234_5FFF, 1'b0, 32'h1234_62B7, 1'b1, 32'hFFF2_8293});
        tbl.push_back('{4'd2,  5'd1,  5'd0, 5'd0, 32'h0000_0800, 1'b1, 32'h0, 1'b0, 32'h0});
        tbl.push_back('{4'd9,  5'd1,  5'd0, 5'd0, 32'hFFFF_F7FF, 1'b1, 32'h0, 1'b0, 32'h0});
        tbl.push_back('{4'd7,  5'd0,  5'd1, 5'd2, 32'h0000_0003, 1'b1, 32'h0, 1'b0, 32'h0});
        tbl.push_back('{4'd8,  5'd0,  5'd1, 5'd2, 32'h0000_1000, 1'b1, 32'h0, 1'b0, 32'h0});
        tbl.push_back('{4'd7,  5'd0,  5'd1, 5'd2, 32'hFFFF_EFFE, 1'b1, 32'h0, 1'b0, 32'h0});
        tbl.push_back('{4'd5,  5'd1,  5'd0, 5'd0, 32'h0000_0001, 1'b1, 32'h0, 1'b0, 32'h0});
        tbl.push_back('{4'd5,  5'd1,  5'd0, 5'd0, 32'h0010_0000, 1'b1, 32'h0, 1'b0, 32'h0});
        tbl.push_back('{4'd3,  5'd1,  5'd0, 5'd0, 32'h0000_0123, 1'b1, 32'h0, 1'b0, 32'h0});
        tbl.push_back('{4'd11, 5'd1,  5'd2, 5'd0, 32'h0000_1000, 1'b1, 32'h0, 1'b0, 32'h0});

        test_reset();
        test_table();
        test_errors();
        test_li();
        test_stall();
        test_reset_mid_li();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter LI_EXPAND, default 1, meaning 1 = LI expands to LUI/ADDI and 0 = LI is an error.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset_i, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port cmd_valid_i, input, 1 bit: command present.
REQ-005 SHALL have port cmd_ready_o, output, 1 bit: command accepted when high together with cmd_valid_i.
REQ-006 SHALL have port cmd_op_i, input, 4 bits, with encoding 0 ADD, 1 SUB, 2 ADDI, 3 LUI, 4 AUIPC, 5 JAL, 6 JALR, 7 BEQ, 8 BNE, 9 LW, 10 SW, 11 CSRRW, 12 ECALL, 13 EBREAK, 14 MRET, 15 LI.
REQ-007 SHALL have ports cmd_rd_i, cmd_rs1_i and cmd_rs2_i, input, 5 bits each: register indices.
REQ-008 SHALL have port cmd_imm_i, input, 32 bits: immediate, byte offset or CSR address.
REQ-009 SHALL have port instr_o, output, 32 bits: encoded RV32I instruction.
REQ-010 SHALL have port instr_valid_o, output, 1 bit: instr_o valid.
REQ-011 SHALL have port instr_ready_i, input, 1 bit: sink consumes instr_o when high with instr_valid_o.
REQ-012 SHALL have port err_o, output, 1 bit: one-cycle pulse when an accepted command is unencodable.

Function
REQ-013 Handshake SHALL be cmd_ready_o = (state==IDLE) && (!instr_valid_o || instr_ready_i).
REQ-014 An instruction for a command accepted in cycle N SHALL appear on instr_o with instr_valid_o high in cycle N+1 (1-cycle latency).
REQ-015 instr_o/instr_valid_o SHALL stay stable while instr_valid_o && !instr_ready_i.
REQ-016 Standard RV32I field placement SHALL be used: R 0x33, I-ALU 0x13, LOAD 0x03, STORE 0x23, BRANCH 0x63, LUI 0x37, AUIPC 0x17, JAL 0x6F, JALR 0x67, SYSTEM 0x73.
REQ-017 SUB SHALL set funct7=0x20; ADD funct7=0; LW/SW funct3=2; BNE funct3=1; CSRRW funct3=1 with csr=imm[11:0], rs1=cmd_rs1_i.
REQ-018 Fixed words: ECALL 0x00000073, EBREAK 0x00100073, MRET 0x30200073; register fields ignored.
REQ-019 Range checks, any failure -> error:
  - ADDI/JALR/LW/SW: imm in [-2048,2047] signed.
  - BEQ/BNE: imm in [-4096,4094] and even.
  - JAL: imm in [-2^20, 2^20-2] and even.
  - LUI/AUIPC: imm[11:0]==0; encoded field = imm[31:12].
  - CSRRW: imm[31:12]==0.
REQ-020 Error SHALL consume the command, emit no instruction, and pulse err_o high exactly in cycle N+1.
REQ-021 LI SHALL behave as follows:
  - If imm fits signed 12 bits: emit ADDI rd,x0,imm.
  - Else hi=(imm+0x800)>>12 [31:12] and lo=imm[11:0]: emit LUI rd,hi, then ADDI rd,rd,lo if lo!=0.
REQ-022 State machine SHALL be IDLE -> LI_LO when LUI is loaded and lo!=0; LI_LO -> IDLE when LUI is consumed and ADDI is loaded in the same cycle.
REQ-023 While in LI_LO, cmd_ready_o SHALL be 0.
REQ-024 ADDI of LI SHALL appear in the cycle after LUI is consumed, or the same cycle's register update when ready is held high; no bubble is required.
REQ-025 LI_EXPAND=0 SHALL make op 15 an error.
REQ-026 rd=x0 SHALL still be encoded, not suppressed.

Reset
REQ-027 While reset_i is high, instr_valid_o=0, err_o=0, cmd_ready_o=0, instr_o=0x00000013 (NOP), state=IDLE.
REQ-028 Reset mid-LI SHALL discard a pending ADDI; the first cycle after reset SHALL have cmd_ready_o=1.

Structure
REQ-029 Opcode constants, op-code enum and NOP value SHALL reside in shared package riscv_pkg, used also by the decoder.
REQ-030 Range checking SHALL be a sub-module imm_range_check (combinational: op, imm -> ok).
REQ-031 The single output register SHALL serve as buffer; no FIFO.

Verification
REQ-032 ADD rd=1 rs1=2 rs2=3 -> instr_o=0x003100B3 one cycle later, err_o=0.
REQ-033 LI rd=5 imm=0x12345FFF -> 0x123462B7 then 0xFFF28293; cmd_ready_o low between them.
REQ-034 ADDI imm=2048 -> err_o pulse one cycle, instr_valid_o stays 0; BEQ imm=3 -> same.
REQ-035 ECALL then MRET with instr_ready_i low 3 cycles -> 0x00000073 held stable, cmd_ready_o=0; then 0x30200073.
REQ-036 Reset asserted after LUI of LI, before consumption -> instr_valid_o=0, no ADDI ever emitted.
REQ-037 Decoder round-trip: every encoded op fed to decoder -> illegal_instr=0.
